// File: rtl/c3po_router_if.sv
// Beat-level bus of the C-3PO router: one wide input stream in, PORTS_P narrow output streams out.
// The master side is the packet source/consumer pair, the slave side is the router.
interface c3po_router_if #(
    parameter int PORTS_P     = 4,
    parameter int IN_BYTES_P  = 160,
    parameter int OUT_BYTES_P = 32,
    parameter int ID_W_P      = 4
) ();
    localparam int VBC_W = $clog2(IN_BYTES_P + 1);

    // Input handshake: a beat transfers on a rising edge where val and in_ready are both high;
    // the source holds every qualifier and the payload steady until that edge. The output side
    // has no backpressure, so o_val marks a beat that the consumer must take in that cycle.
    logic                                 val;
    logic                                 sop;
    logic                                 eop;
    logic [ID_W_P-1:0]                    id;
    logic [VBC_W-1:0]                     vbc;
    logic [IN_BYTES_P*8-1:0]              data;
    logic                                 in_ready;

    logic [PORTS_P-1:0]                   o_val;
    logic [PORTS_P-1:0]                   o_sop;
    logic [PORTS_P-1:0]                   o_eop;
    logic [PORTS_P*VBC_W-1:0]             o_vbc;
    logic [PORTS_P*OUT_BYTES_P*8-1:0]     o_data;

    modport master (
        output val, sop, eop, id, vbc, data,
        input  in_ready, o_val, o_sop, o_eop, o_vbc, o_data
    );

    modport slave (
        input  val, sop, eop, id, vbc, data,
        output in_ready, o_val, o_sop, o_eop, o_vbc, o_data
    );
endinterface

// File: rtl/c3po_router.sv
// C-3PO packet distributor: steers wide input beats by packet id to one of PORTS_P slices,
// unpacks them into OUT_BYTES_P beats and keeps per-port and drop statistics.
module c3po_router #(
    parameter int PORTS_P     = 4,
    parameter int IN_BYTES_P  = 160,
    parameter int OUT_BYTES_P = 32,
    parameter int ID_W_P      = 4,
    parameter int CNT_SIZE_P  = 8,
    parameter int CNT_SAT_P   = 0
) (
    input  logic                          clk,
    input  logic                          reset_L,
    c3po_router_if.slave                  bus,
    input  logic [PORTS_P*ID_W_P-1:0]     cfg_port_id,
    input  logic [PORTS_P-1:0]            cfg_port_enable,
    input  logic [PORTS_P-1:0]            cnt_clr,
    output logic [PORTS_P*CNT_SIZE_P-1:0] pkt_cnt,
    output logic [PORTS_P*CNT_SIZE_P-1:0] byte_cnt,
    output logic [CNT_SIZE_P-1:0]         drop_cnt,
    output logic                          err,
    output logic [0:0]                    fsm_state
);
    localparam int VBC_W = $clog2(IN_BYTES_P + 1);
    localparam int IN_W  = IN_BYTES_P * 8;
    localparam int OUT_W = OUT_BYTES_P * 8;
    localparam int IDX_W = (PORTS_P > 1) ? $clog2(PORTS_P) : 1;
    localparam int SUM_W = ((CNT_SIZE_P > VBC_W) ? CNT_SIZE_P : VBC_W) + 1;
    localparam logic [VBC_W-1:0] OUT_B = VBC_W'(OUT_BYTES_P);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PKT  = 1'b1;

    function automatic logic [CNT_SIZE_P-1:0] sat_add(input logic [CNT_SIZE_P-1:0] a,
                                                      input logic [VBC_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (CNT_SAT_P != 0 && s > SUM_W'({CNT_SIZE_P{1'b1}}))
            return {CNT_SIZE_P{1'b1}};
        return s[CNT_SIZE_P-1:0];
    endfunction

    logic [0:0]         state_q;
    logic [IDX_W-1:0]   tgt_q;
    logic               tgt_vld_q;
    logic               err_q;
    logic [CNT_SIZE_P-1:0] drop_q;
    logic [PORTS_P-1:0] port_ready;

    logic               hit_any;
    logic [IDX_W-1:0]   hit_idx;
    logic [IDX_W-1:0]   cur_idx;
    logic               cur_vld;
    logic               accept;
    logic               bad;
    logic               good;
    logic               fwd;
    logic [VBC_W-1:0]   drop_inc;

    // A sop beat picks its port from the live id; continuation beats follow the port latched at sop.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = PORTS_P - 1; i >= 0; i--) begin
            if (bus.id == cfg_port_id[i*ID_W_P +: ID_W_P]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        if (bus.sop) begin
            cur_idx = hit_idx;
            cur_vld = hit_any && cfg_port_enable[hit_idx];
        end else begin
            cur_idx = tgt_q;
            cur_vld = (state_q == ST_PKT) && tgt_vld_q;
        end
    end

    assign bus.in_ready = cur_vld ? port_ready[cur_idx] : 1'b1;
    assign accept       = bus.val && bus.in_ready;
    assign bad          = (bus.vbc == '0) || (!bus.sop && state_q == ST_IDLE);
    assign good         = accept && !bad;
    assign fwd          = good && cur_vld;

    always_comb begin
        drop_inc = '0;
        if (good && bus.sop && state_q == ST_PKT)
            drop_inc = drop_inc + VBC_W'(1);
        if (good && bus.eop && !cur_vld)
            drop_inc = drop_inc + VBC_W'(1);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_IDLE;
            tgt_q     <= '0;
            tgt_vld_q <= 1'b0;
            err_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            err_q  <= accept && (bad || (bus.sop && state_q == ST_PKT));
            drop_q <= sat_add(drop_q, drop_inc);
            if (good) begin
                if (bus.sop) begin
                    tgt_q     <= cur_idx;
                    tgt_vld_q <= cur_vld;
                    state_q   <= bus.eop ? ST_IDLE : ST_PKT;
                end else if (bus.eop) begin
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    assign err       = err_q;
    assign drop_cnt  = drop_q;
    assign fsm_state = state_q;

    for (genvar p = 0; p < PORTS_P; p++) begin : g_port
        logic [IN_W-1:0]       shift_q;
        logic [VBC_W-1:0]      left_q;
        logic                  eop_q;
        logic                  val_q;
        logic                  sop_q;
        logic                  oeop_q;
        logic [VBC_W-1:0]      vbc_q;
        logic [OUT_W-1:0]      data_q;
        logic [CNT_SIZE_P-1:0] pkt_q;
        logic [CNT_SIZE_P-1:0] byte_q;
        logic                  load;
        logic [VBC_W-1:0]      first_vbc;
        logic [VBC_W-1:0]      next_vbc;

        assign load          = fwd && (cur_idx == IDX_W'(p));
        assign first_vbc     = (bus.vbc > OUT_B) ? OUT_B : bus.vbc;
        assign next_vbc      = (left_q > OUT_B) ? OUT_B : left_q;
        // left_q counts bytes still to be emitted after the beat currently on the outputs.
        assign port_ready[p] = (left_q == '0);

        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                shift_q <= '0;
                left_q  <= '0;
                eop_q   <= 1'b0;
                val_q   <= 1'b0;
                sop_q   <= 1'b0;
                oeop_q  <= 1'b0;
                vbc_q   <= '0;
                data_q  <= '0;
                pkt_q   <= '0;
                byte_q  <= '0;
            end else begin
                if (left_q != '0) begin
                    val_q   <= 1'b1;
                    sop_q   <= 1'b0;
                    oeop_q  <= eop_q && (left_q <= OUT_B);
                    vbc_q   <= next_vbc;
                    data_q  <= shift_q[OUT_W-1:0];
                    shift_q <= shift_q >> OUT_W;
                    left_q  <= left_q - next_vbc;
                end else if (load) begin
                    val_q   <= 1'b1;
                    sop_q   <= bus.sop;
                    oeop_q  <= bus.eop && (bus.vbc <= OUT_B);
                    vbc_q   <= first_vbc;
                    data_q  <= bus.data[OUT_W-1:0];
                    shift_q <= bus.data >> OUT_W;
                    left_q  <= bus.vbc - first_vbc;
                    eop_q   <= bus.eop;
                end else begin
                    val_q  <= 1'b0;
                    sop_q  <= 1'b0;
                    oeop_q <= 1'b0;
                    vbc_q  <= '0;
                    data_q <= '0;
                end

                if (cnt_clr[p]) begin
                    pkt_q  <= '0;
                    byte_q <= '0;
                end else if (load) begin
                    byte_q <= sat_add(byte_q, bus.vbc);
                    if (bus.eop)
                        pkt_q <= sat_add(pkt_q, VBC_W'(1));
                end
            end
        end

        assign bus.o_val[p]                     = val_q;
        assign bus.o_sop[p]                     = sop_q;
        assign bus.o_eop[p]                     = oeop_q;
        assign bus.o_vbc[p*VBC_W +: VBC_W]      = vbc_q;
        assign bus.o_data[p*OUT_W +: OUT_W]     = data_q;
        assign pkt_cnt[p*CNT_SIZE_P +: CNT_SIZE_P]  = pkt_q;
        assign byte_cnt[p*CNT_SIZE_P +: CNT_SIZE_P] = byte_q;
    end
endmodule

// File: tb/tb_c3po_router.sv
// Directed bench for c3po_router: a wrapping and a saturating instance share one stimulus stream,
// with hand-computed expectations checked by immediate assertions.
module tb_c3po_router;
    logic          clk = 1'b0;
    logic          reset_L;
    logic          val, sop, eop;
    logic [3:0]    id;
    logic [7:0]    vbc;
    logic [1279:0] data;
    logic [15:0]   cfg_port_id;
    logic [3:0]    cfg_port_enable;
    logic [3:0]    cnt_clr;

    logic [31:0]   pkt_cnt, byte_cnt, pkt_cnt_s, byte_cnt_s;
    logic [7:0]    drop_cnt, drop_cnt_s;
    logic          err, err_s;
    logic [0:0]    fsm_state, fsm_state_s;

    int            n_checks = 0;
    int            n_err = 0;
    int            w;
    logic [1279:0] d;

    int            beats [4] = '{0, 0, 0, 0};
    int            bytes [4] = '{0, 0, 0, 0};
    int            sops  [4] = '{0, 0, 0, 0};
    int            eops  [4] = '{0, 0, 0, 0};
    logic [7:0]    last_vbc [4];
    logic          last_eop [4];
    int            snap_b, snap_y, snap_s, snap_e, snap_3, snap_t;

    always #5 clk = ~clk;

    c3po_router_if #(.PORTS_P(4), .IN_BYTES_P(160), .OUT_BYTES_P(32), .ID_W_P(4)) bus ();
    c3po_router_if #(.PORTS_P(4), .IN_BYTES_P(160), .OUT_BYTES_P(32), .ID_W_P(4)) bus_s ();

    assign bus.val   = val;   assign bus_s.val  = val;
    assign bus.sop   = sop;   assign bus_s.sop  = sop;
    assign bus.eop   = eop;   assign bus_s.eop  = eop;
    assign bus.id    = id;    assign bus_s.id   = id;
    assign bus.vbc   = vbc;   assign bus_s.vbc  = vbc;
    assign bus.data  = data;  assign bus_s.data = data;

    c3po_router #(.CNT_SAT_P(0)) dut (
        .clk(clk), .reset_L(reset_L), .bus(bus),
        .cfg_port_id(cfg_port_id), .cfg_port_enable(cfg_port_enable), .cnt_clr(cnt_clr),
        .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .drop_cnt(drop_cnt),
        .err(err), .fsm_state(fsm_state)
    );

    c3po_router #(.CNT_SAT_P(1)) dut_sat (
        .clk(clk), .reset_L(reset_L), .bus(bus_s),
        .cfg_port_id(cfg_port_id), .cfg_port_enable(cfg_port_enable), .cnt_clr(cnt_clr),
        .pkt_cnt(pkt_cnt_s), .byte_cnt(byte_cnt_s), .drop_cnt(drop_cnt_s),
        .err(err_s), .fsm_state(fsm_state_s)
    );

    // Output beat monitor for the wrapping instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_L) begin
            for (int p = 0; p < 4; p++) begin
                if (bus.o_val[p]) begin
                    beats[p]    = beats[p] + 1;
                    bytes[p]    = bytes[p] + int'(bus.o_vbc[p*8 +: 8]);
                    sops[p]     = sops[p] + int'(bus.o_sop[p]);
                    eops[p]     = eops[p] + int'(bus.o_eop[p]);
                    last_vbc[p] = bus.o_vbc[p*8 +: 8];
                    last_eop[p] = bus.o_eop[p];
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1279:0] mk_data(input int seed);
        logic [1279:0] r;
        r = '0;
        for (int b = 0; b < 160; b++)
            r[b*8 +: 8] = 8'(b * 3 + seed);
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat, waits (bounded) for in_ready, and returns 1ns after the accepting edge.
    task automatic send(input logic s, input logic e, input logic [3:0] i, input logic [7:0] n,
                        input int seed, input logic [3:0] clr, output int waited);
        sop = s; eop = e; id = i; vbc = n; data = mk_data(seed); val = 1'b1;
        waited = 0;
        #1;
        while (!bus.in_ready && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("send_timeout", 256'(waited < 40), 256'(1));
        cnt_clr = clr;
        @(posedge clk);
        #1;
        val = 1'b0; sop = 1'b0; eop = 1'b0; cnt_clr = '0;
    endtask

    initial begin
        reset_L = 1'b0;
        val = 1'b0; sop = 1'b0; eop = 1'b0; id = '0; vbc = '0; data = '0; cnt_clr = '0;
        cfg_port_id     = {4'd5, 4'd12, 4'd5, 4'd3};
        cfg_port_enable = 4'hf;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_o_val", bus.o_val, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_err", err, 0);
        check("rst_fsm", fsm_state, 0);
        @(negedge clk);
        reset_L = 1'b1;
        tick();

        // Single 70-byte packet to port 0: 32, 32, 6
        send(1, 1, 4'd3, 8'd70, 1, 4'h0, w);
        d = mk_data(1);
        check("t1_b1_val", bus.o_val, 4'b0001);
        check("t1_b1_sop", bus.o_sop, 4'b0001);
        check("t1_b1_eop", bus.o_eop, 4'b0000);
        check("t1_b1_vbc", bus.o_vbc[7:0], 32);
        check("t1_b1_data", bus.o_data[255:0], d[255:0]);
        check("t1_pkt_cnt0", pkt_cnt[7:0], 1);
        check("t1_byte_cnt0", byte_cnt[7:0], 70);
        tick();
        check("t1_b2_vbc", bus.o_vbc[7:0], 32);
        check("t1_b2_sopeop", {bus.o_sop[0], bus.o_eop[0]}, 2'b00);
        check("t1_b2_data", bus.o_data[255:0], d[511:256]);
        tick();
        check("t1_b3_val", bus.o_val, 4'b0001);
        check("t1_b3_vbc", bus.o_vbc[7:0], 6);
        check("t1_b3_sopeop", {bus.o_sop[0], bus.o_eop[0]}, 2'b01);
        check("t1_b3_data", bus.o_data[255:0], d[767:512]);
        tick();
        check("t1_idle_val", bus.o_val, 0);
        check("t1_idle_data", bus.o_data[255:0], 0);
        check("t1_idle_vbc", bus.o_vbc[7:0], 0);

        // Back-to-back single-beat packets
        cnt_clr = 4'b0001;
        tick();
        cnt_clr = '0;
        check("t2_clr_byte0", byte_cnt[7:0], 0);
        for (int k = 0; k < 4; k++) begin
            send(1, 1, 4'd3, 8'd32, 10 + k, 4'h0, w);
            d = mk_data(10 + k);
            check("t2_no_wait", w, 0);
            check("t2_val", bus.o_val, 4'b0001);
            check("t2_sopeop", {bus.o_sop[0], bus.o_eop[0]}, 2'b11);
            check("t2_data", bus.o_data[255:0], d[255:0]);
        end
        check("t2_byte_cnt0", byte_cnt[7:0], 128);
        check("t2_byte_cnt0_sat", byte_cnt_s[7:0], 128);
        check("t2_pkt_cnt0", pkt_cnt[7:0], 4);
        tick();
        check("t2_idle_val", bus.o_val, 0);

        // 3-beat packet to port 1 (beats port 3 on equal id), enable dropped mid-packet
        snap_b = beats[1]; snap_y = bytes[1]; snap_s = sops[1]; snap_e = eops[1]; snap_3 = beats[3];
        send(1, 0, 4'd5, 8'd160, 20, 4'h0, w);
        check("t3_lowest_wins", bus.o_val, 4'b0010);
        check("t3_fsm_pkt", fsm_state, 1);
        cfg_port_enable = 4'b1101;
        #1;
        check("t3_busy_ready", bus.in_ready, 0);
        send(0, 0, 4'd9, 8'd160, 21, 4'h0, w);
        check("t3_wait_b2", w, 4);
        send(0, 1, 4'd9, 8'd10, 22, 4'h0, w);
        check("t3_wait_b3", w, 4);
        tick();
        tick();
        check("t3_beats", beats[1] - snap_b, 11);
        check("t3_bytes", bytes[1] - snap_y, 330);
        check("t3_sops", sops[1] - snap_s, 1);
        check("t3_eops", eops[1] - snap_e, 1);
        check("t3_last_vbc", last_vbc[1], 10);
        check("t3_last_eop", last_eop[1], 1);
        check("t3_port3_quiet", beats[3] - snap_3, 0);
        check("t3_pkt_cnt1", pkt_cnt[15:8], 1);
        check("t3_byte_cnt1_wrap", byte_cnt[15:8], 74);
        check("t3_byte_cnt1_sat", byte_cnt_s[15:8], 255);
        check("t3_fsm_idle", fsm_state, 0);
        cfg_port_enable = 4'hf;

        // Discarded packets: no match, then disabled port
        snap_t = beats[0] + beats[1] + beats[2] + beats[3];
        send(1, 1, 4'd9, 8'd40, 30, 4'h0, w);
        check("t4_nomatch_wait", w, 0);
        check("t4_drop1", drop_cnt, 1);
        cfg_port_enable = 4'b1110;
        send(1, 1, 4'd3, 8'd40, 31, 4'h0, w);
        check("t4_drop2", drop_cnt, 2);
        check("t4_drop2_sat", drop_cnt_s, 2);
        check("t4_in_ready", bus.in_ready, 1);
        tick();
        tick();
        check("t4_no_beats", beats[0] + beats[1] + beats[2] + beats[3] - snap_t, 0);
        check("t4_pkt_cnt0", pkt_cnt[7:0], 4);
        cfg_port_enable = 4'hf;

        // Counter saturation / wrap and clear priority
        cnt_clr = 4'b0001;
        tick();
        cnt_clr = '0;
        send(1, 1, 4'd3, 8'd160, 40, 4'h0, w);
        send(1, 1, 4'd3, 8'd160, 41, 4'h0, w);
        check("t5_wait", w, 4);
        check("t5_byte_sat", byte_cnt_s[7:0], 255);
        check("t5_byte_wrap", byte_cnt[7:0], 64);
        check("t5_pkt", pkt_cnt[7:0], 2);
        send(1, 1, 4'd3, 8'd160, 42, 4'b0001, w);
        check("t5_clr_byte_sat", byte_cnt_s[7:0], 0);
        check("t5_clr_pkt_sat", pkt_cnt_s[7:0], 0);
        check("t5_clr_byte", byte_cnt[7:0], 0);
        repeat (6) tick();

        // Non-sop beat while idle
        snap_b = beats[0];
        send(0, 1, 4'd3, 8'd50, 50, 4'h0, w);
        check("idle_beat_err", err, 1);
        check("idle_beat_err_sat", err_s, 1);
        check("idle_beat_byte", byte_cnt[7:0], 0);
        check("idle_beat_drop", drop_cnt, 2);
        tick();
        check("idle_beat_err_pulse", err, 0);
        check("idle_beat_no_out", beats[0] - snap_b, 0);

        // sop inside a packet, then reset during unpack
        send(1, 0, 4'd3, 8'd32, 60, 4'h0, w);
        check("t6_fsm_pkt", fsm_state, 1);
        check("t6_no_err", err, 0);
        send(1, 0, 4'd3, 8'd160, 61, 4'h0, w);
        d = mk_data(61);
        check("t6_err", err, 1);
        check("t6_drop3", drop_cnt, 3);
        check("t6_drop3_sat", drop_cnt_s, 3);
        check("t6_new_sop", bus.o_sop, 4'b0001);
        check("t6_byte0", byte_cnt[7:0], 192);
        tick();
        check("t6_err_pulse", err, 0);
        check("t6_b2_val", bus.o_val, 4'b0001);
        check("t6_b2_data", bus.o_data[255:0], d[511:256]);
        #2;
        reset_L = 1'b0;
        #1;
        check("t6_rst_val", bus.o_val, 0);
        check("t6_rst_data", bus.o_data[255:0], 0);
        check("t6_rst_drop", drop_cnt, 0);
        check("t6_rst_byte", byte_cnt[7:0], 0);
        check("t6_rst_fsm", fsm_state, 0);
        check("t6_rst_ready", bus.in_ready, 1);
        snap_b = beats[0];
        @(negedge clk);
        reset_L = 1'b1;
        repeat (6) tick();
        check("t6_post_rst_quiet", beats[0] - snap_b, 0);
        check("t6_post_rst_val", bus.o_val, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
